// File: rtl/dma_priority_logic_if.sv
// dma_priority_logic_if
//   Groups the request/acknowledge bus between the DMA controller and the
//   channel priority arbiter.
//   Handshake: a channel is requested through DREQ/requestReg (pending); the
//   arbiter answers with a registered one-hot VALID_DREQ plus grantValid, and
//   DACK becomes active only while the timing FSM holds validDACK. The
//   transfer ends on a one-cycle serviceDone pulse.
//   master : controller/timing side (drives requests, config, timing strobes)
//   slave  : arbiter side (drives grant, DACK and the debug view)
//   Debug  : arbState (one-hot FSM state), lowPri (rotation pointer)
interface dma_priority_logic_if;
  logic [3:0] DREQ;
  logic [7:0] commandReg;
  logic [3:0] maskReg;
  logic [3:0] requestReg;
  logic       idleCycle;
  logic       validDACK;
  logic       serviceDone;
  logic [3:0] VALID_DREQ;
  logic [3:0] DACK;
  logic [1:0] activeChannel;
  logic       grantValid;
  logic [2:0] arbState;
  logic [1:0] lowPri;

  modport master (
    output DREQ, commandReg, maskReg, requestReg, idleCycle, validDACK, serviceDone,
    input  VALID_DREQ, DACK, activeChannel, grantValid, arbState, lowPri
  );

  modport slave (
    input  DREQ, commandReg, maskReg, requestReg, idleCycle, validDACK, serviceDone,
    output VALID_DREQ, DACK, activeChannel, grantValid, arbState, lowPri
  );
endinterface

// File: rtl/dma_priority_logic.sv
// dma_priority_logic
//   Four-channel DMA priority arbiter. Requests are normalized and registered
//   once, combined with masks and software requests, and arbitrated with fixed
//   or rotating priority. A grant is held through the transfer once the
//   acknowledge window opens, and released through a one-cycle update state
//   that also advances the rotation pointer.
//   Ports:
//     CLK   - sole clock, rising edge
//     RESET - synchronous active-high reset
//     bus   - dma_priority_logic_if.slave (requests, config, grant, DACK, debug)
module dma_priority_logic (
  input  logic CLK,
  input  logic RESET,
  dma_priority_logic_if.slave bus
);

  localparam logic [2:0] ARB_IDLE   = 3'b001;
  localparam logic [2:0] ARB_GRANT  = 3'b010;
  localparam logic [2:0] ARB_UPDATE = 3'b100;

  logic [2:0] state;
  logic [3:0] dreqSync;
  logic [3:0] validDreq;
  logic [1:0] activeCh;
  logic       grantReg;
  logic [1:0] lowPri;
  logic       dackSeen;

  logic [3:0] pending;
  logic [1:0] winner;
  logic [3:0] activeVector;

  // Highest-ranked pending channel. Search runs from the lowest rank upward
  // so the last hit (the highest rank) wins.
  function automatic logic [1:0] pickWinner(input logic [3:0] pend,
                                            input logic       rotate,
                                            input logic [1:0] lp);
    logic [1:0] start;
    logic [1:0] idx;
    pickWinner = 2'd0;
    start = rotate ? (lp + 2'd1) : 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (pend[idx]) pickWinner = idx;
    end
  endfunction

  assign pending = (dreqSync & ~bus.maskReg) | bus.requestReg;
  assign winner  = pickWinner(pending, bus.commandReg[4], lowPri);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ARB_IDLE;
      dreqSync  <= 4'd0;
      validDreq <= 4'd0;
      activeCh  <= 2'd0;
      grantReg  <= 1'b0;
      lowPri    <= 2'd3;
      dackSeen  <= 1'b0;
    end else begin
      dreqSync <= bus.DREQ ^ {4{bus.commandReg[6]}};
      case (state)
        ARB_IDLE: begin
          // serviceDone is meaningless here and deliberately ignored.
          if (bus.idleCycle && (pending != 4'd0) && !bus.commandReg[2]) begin
            state     <= ARB_GRANT;
            validDreq <= 4'b0001 << winner;
            activeCh  <= winner;
            grantReg  <= 1'b1;
            dackSeen  <= 1'b0;
          end
        end
        ARB_GRANT: begin
          if (bus.serviceDone) begin
            state <= ARB_UPDATE;
          end else if (bus.validDACK) begin
            // From here on the grant is locked until serviceDone.
            dackSeen <= 1'b1;
          end else if (!dackSeen && !pending[activeCh]) begin
            // Request withdrawn before acknowledge: drop without rotating.
            state     <= ARB_IDLE;
            validDreq <= 4'd0;
            activeCh  <= 2'd0;
            grantReg  <= 1'b0;
          end
        end
        ARB_UPDATE: begin
          state     <= ARB_IDLE;
          validDreq <= 4'd0;
          activeCh  <= 2'd0;
          grantReg  <= 1'b0;
          dackSeen  <= 1'b0;
          if (bus.commandReg[4]) lowPri <= activeCh;
        end
        default: begin
          state     <= ARB_IDLE;
          validDreq <= 4'd0;
          activeCh  <= 2'd0;
          grantReg  <= 1'b0;
          dackSeen  <= 1'b0;
        end
      endcase
    end
  end

  // DACK follows the registered grant, gated by the acknowledge window;
  // commandReg[7]=0 makes the pins active-low.
  assign activeVector      = validDreq & {4{bus.validDACK}};
  assign bus.DACK          = activeVector ^ {4{~bus.commandReg[7]}};
  assign bus.VALID_DREQ    = validDreq;
  assign bus.activeChannel = activeCh;
  assign bus.grantValid    = grantReg;
  assign bus.arbState      = state;
  assign bus.lowPri        = lowPri;

endmodule

// File: tb/tb_dma_priority_logic.sv
module tb_dma_priority_logic;
  logic CLK;
  logic RESET;
  int   checks;
  int   failures;

  dma_priority_logic_if bus ();

  dma_priority_logic dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  // Clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [2:0] S_IDLE   = 3'b001;
  localparam logic [2:0] S_GRANT  = 3'b010;
  localparam logic [2:0] S_UPDATE = 3'b100;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Driver: open the acknowledge window, finish the transfer, and run the
  // update cycle. Leaves the arbiter in idle with the given requests applied.
  task automatic serve(input logic [3:0] newDreq, input logic [3:0] newReq);
    bus.validDACK = 1'b1;
    step();
    bus.serviceDone = 1'b1;
    bus.DREQ        = newDreq;
    bus.requestReg  = newReq;
    step();
    bus.serviceDone = 1'b0;
    bus.validDACK   = 1'b0;
    step();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    checks += 6;
    if (bus.VALID_DREQ !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=%b", bus.VALID_DREQ, 4'b0000); end
    if (bus.grantValid !== 1'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0", bus.grantValid); end
    if (bus.activeChannel !== 2'd0) begin failures++; $display("FAIL reset_chan got=%0d exp=0", bus.activeChannel); end
    if (bus.DACK !== 4'hF) begin failures++; $display("FAIL reset_dack got=%b exp=1111", bus.DACK); end
    if (bus.lowPri !== 2'd3) begin failures++; $display("FAIL reset_lowpri got=%0d exp=3", bus.lowPri); end
    if (bus.arbState !== S_IDLE) begin failures++; $display("FAIL reset_state got=%b exp=%b", bus.arbState, S_IDLE); end
  endtask

  task automatic test_fixed();
    bus.DREQ = 4'b1010;
    step();
    checks++;
    if (bus.VALID_DREQ !== 4'b0000) begin failures++; $display("FAIL fixed_latency1 got=%b exp=0000", bus.VALID_DREQ); end
    step();
    checks += 4;
    if (bus.VALID_DREQ !== 4'b0010) begin failures++; $display("FAIL fixed_valid got=%b exp=0010", bus.VALID_DREQ); end
    if (bus.activeChannel !== 2'd1) begin failures++; $display("FAIL fixed_chan got=%0d exp=1", bus.activeChannel); end
    if (bus.grantValid !== 1'b1) begin failures++; $display("FAIL fixed_grant got=%b exp=1", bus.grantValid); end
    if (bus.DACK !== 4'b1111) begin failures++; $display("FAIL fixed_dack_idle got=%b exp=1111", bus.DACK); end
    bus.validDACK = 1'b1;
    #1;
    checks++;
    if (bus.DACK !== 4'b1101) begin failures++; $display("FAIL fixed_dack_active got=%b exp=1101", bus.DACK); end
    step();
    bus.serviceDone = 1'b1;
    bus.DREQ        = 4'b0000;
    step();
    bus.serviceDone = 1'b0;
    bus.validDACK   = 1'b0;
    checks += 2;
    if (bus.arbState !== S_UPDATE) begin failures++; $display("FAIL fixed_update_state got=%b exp=%b", bus.arbState, S_UPDATE); end
    if (bus.VALID_DREQ !== 4'b0010) begin failures++; $display("FAIL fixed_update_hold got=%b exp=0010", bus.VALID_DREQ); end
    step();
    checks += 3;
    if (bus.arbState !== S_IDLE) begin failures++; $display("FAIL fixed_release_state got=%b exp=%b", bus.arbState, S_IDLE); end
    if (bus.VALID_DREQ !== 4'b0000) begin failures++; $display("FAIL fixed_release_valid got=%b exp=0000", bus.VALID_DREQ); end
    if (bus.lowPri !== 2'd3) begin failures++; $display("FAIL fixed_lowpri got=%0d exp=3", bus.lowPri); end
  endtask

  task automatic test_rotating();
    bus.commandReg = 8'h10;
    bus.DREQ       = 4'b0100;
    step();
    step();
    checks++;
    if (bus.activeChannel !== 2'd2) begin failures++; $display("FAIL rot_first got=%0d exp=2", bus.activeChannel); end
    serve(4'b1101, 4'b0000);
    checks += 2;
    if (bus.lowPri !== 2'd2) begin failures++; $display("FAIL rot_lowpri2 got=%0d exp=2", bus.lowPri); end
    if (bus.grantValid !== 1'b0) begin failures++; $display("FAIL rot_no_early_grant got=%b exp=0", bus.grantValid); end
    step();
    checks += 2;
    if (bus.activeChannel !== 2'd3) begin failures++; $display("FAIL rot_ch3 got=%0d exp=3", bus.activeChannel); end
    if (bus.VALID_DREQ !== 4'b1000) begin failures++; $display("FAIL rot_ch3_vec got=%b exp=1000", bus.VALID_DREQ); end
    serve(4'b1101, 4'b0000);
    step();
    checks += 2;
    if (bus.activeChannel !== 2'd0) begin failures++; $display("FAIL rot_ch0 got=%0d exp=0", bus.activeChannel); end
    if (bus.grantValid !== 1'b1) begin failures++; $display("FAIL rot_ch0_grant got=%b exp=1", bus.grantValid); end
    serve(4'b1101, 4'b0000);
    step();
    checks++;
    if (bus.activeChannel !== 2'd2) begin failures++; $display("FAIL rot_ch2 got=%0d exp=2", bus.activeChannel); end
    serve(4'b0000, 4'b0000);
    bus.commandReg = 8'h00;
    checks++;
    if (bus.lowPri !== 2'd2) begin failures++; $display("FAIL rot_final_lowpri got=%0d exp=2", bus.lowPri); end
  endtask

  task automatic test_masking();
    bus.maskReg    = 4'b0001;
    bus.DREQ       = 4'b0001;
    bus.requestReg = 4'b0001;
    step();
    step();
    checks += 2;
    if (bus.VALID_DREQ !== 4'b0001) begin failures++; $display("FAIL mask_sw_valid got=%b exp=0001", bus.VALID_DREQ); end
    if (bus.grantValid !== 1'b1) begin failures++; $display("FAIL mask_sw_grant got=%b exp=1", bus.grantValid); end
    serve(4'b0001, 4'b0000);
    step();
    step();
    checks += 2;
    if (bus.grantValid !== 1'b0) begin failures++; $display("FAIL mask_hw_grant got=%b exp=0", bus.grantValid); end
    if (bus.VALID_DREQ !== 4'b0000) begin failures++; $display("FAIL mask_hw_valid got=%b exp=0000", bus.VALID_DREQ); end
    bus.maskReg = 4'b0000;
    bus.DREQ    = 4'b0000;
    step();
  endtask

  task automatic test_withdrawal();
    bus.DREQ = 4'b0010;
    step();
    step();
    checks++;
    if (bus.activeChannel !== 2'd1) begin failures++; $display("FAIL wd_grant got=%0d exp=1", bus.activeChannel); end
    bus.DREQ = 4'b0000;
    step();
    step();
    checks += 4;
    if (bus.arbState !== S_IDLE) begin failures++; $display("FAIL wd_state got=%b exp=%b", bus.arbState, S_IDLE); end
    if (bus.VALID_DREQ !== 4'b0000) begin failures++; $display("FAIL wd_valid got=%b exp=0000", bus.VALID_DREQ); end
    if (bus.grantValid !== 1'b0) begin failures++; $display("FAIL wd_grantvalid got=%b exp=0", bus.grantValid); end
    if (bus.lowPri !== 2'd2) begin failures++; $display("FAIL wd_lowpri got=%0d exp=2", bus.lowPri); end
  endtask

  task automatic test_polarity();
    bus.commandReg = 8'hC0;
    bus.DREQ       = 4'b1110;
    step();
    step();
    checks += 2;
    if (bus.VALID_DREQ !== 4'b0001) begin failures++; $display("FAIL pol_valid got=%b exp=0001", bus.VALID_DREQ); end
    if (bus.DACK !== 4'b0000) begin failures++; $display("FAIL pol_dack_idle got=%b exp=0000", bus.DACK); end
    bus.validDACK = 1'b1;
    #1;
    checks++;
    if (bus.DACK !== 4'b0001) begin failures++; $display("FAIL pol_dack got=%b exp=0001", bus.DACK); end
    serve(4'b1111, 4'b0000);
    bus.commandReg = 8'h00;
    bus.DREQ       = 4'b0000;
    step();
  endtask

  task automatic test_hold_and_disable();
    // Idle serviceDone and controller disable must not produce a grant.
    bus.serviceDone = 1'b1;
    step();
    bus.serviceDone = 1'b0;
    bus.commandReg  = 8'h04;
    bus.DREQ        = 4'b0001;
    step();
    step();
    step();
    checks += 2;
    if (bus.arbState !== S_IDLE) begin failures++; $display("FAIL dis_state got=%b exp=%b", bus.arbState, S_IDLE); end
    if (bus.grantValid !== 1'b0) begin failures++; $display("FAIL dis_grant got=%b exp=0", bus.grantValid); end
    bus.commandReg = 8'h00;
    step();
    checks++;
    if (bus.VALID_DREQ !== 4'b0001) begin failures++; $display("FAIL dis_release got=%b exp=0001", bus.VALID_DREQ); end
    // Once acknowledged, the grant survives masking, withdrawal and disable.
    bus.validDACK = 1'b1;
    step();
    bus.validDACK  = 1'b0;
    bus.maskReg    = 4'b1111;
    bus.DREQ       = 4'b0000;
    bus.commandReg = 8'h04;
    step();
    step();
    checks += 2;
    if (bus.VALID_DREQ !== 4'b0001) begin failures++; $display("FAIL hold_valid got=%b exp=0001", bus.VALID_DREQ); end
    if (bus.arbState !== S_GRANT) begin failures++; $display("FAIL hold_state got=%b exp=%b", bus.arbState, S_GRANT); end
    serve(4'b0000, 4'b0000);
    bus.maskReg    = 4'b0000;
    bus.commandReg = 8'h00;
    checks++;
    if (bus.grantValid !== 1'b0) begin failures++; $display("FAIL hold_done got=%b exp=0", bus.grantValid); end
  endtask

  task automatic test_reset_mid();
    bus.DREQ = 4'b0100;
    step();
    step();
    bus.validDACK = 1'b1;
    step();
    checks++;
    if (bus.activeChannel !== 2'd2) begin failures++; $display("FAIL rstmid_pre got=%0d exp=2", bus.activeChannel); end
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    checks += 5;
    if (bus.VALID_DREQ !== 4'b0000) begin failures++; $display("FAIL rstmid_valid got=%b exp=0000", bus.VALID_DREQ); end
    if (bus.grantValid !== 1'b0) begin failures++; $display("FAIL rstmid_grant got=%b exp=0", bus.grantValid); end
    if (bus.DACK !== 4'hF) begin failures++; $display("FAIL rstmid_dack got=%b exp=1111", bus.DACK); end
    if (bus.lowPri !== 2'd3) begin failures++; $display("FAIL rstmid_lowpri got=%0d exp=3", bus.lowPri); end
    if (bus.arbState !== S_IDLE) begin failures++; $display("FAIL rstmid_state got=%b exp=%b", bus.arbState, S_IDLE); end
    bus.validDACK = 1'b0;
    bus.DREQ      = 4'b0000;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    RESET           = 1'b1;
    bus.DREQ        = 4'b0000;
    bus.commandReg  = 8'h00;
    bus.maskReg     = 4'b0000;
    bus.requestReg  = 4'b0000;
    bus.idleCycle   = 1'b1;
    bus.validDACK   = 1'b0;
    bus.serviceDone = 1'b0;
    test_reset();
    test_fixed();
    test_rotating();
    test_masking();
    test_withdrawal();
    test_polarity();
    test_hold_and_disable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
